// File: rtl/score_digit_encoder_if.sv
// Value handshake from game logic plus the committed digit codes sent to the glyph renderers.
interface score_digit_encoder_if #(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
);
  logic [VALUE_W-1:0]      value;
  logic                    value_valid;
  logic                    ready;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    updated;

  modport master (
    output value, value_valid,
    input  ready, digits, updated
  );

  modport slave (
    input  value, value_valid,
    output ready, digits, updated
  );
endinterface

// File: rtl/score_digit_encoder.sv
// Binary-to-BCD (double dabble, VALUE_W cycles, ready low while busy; extra offers dropped).
// Results are staged and only committed to the digit outputs at x==0, y==COMMIT_LINE.
module score_digit_encoder #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int COMMIT_LINE = 490,
  parameter bit LEAD_BLANK  = 1'b1
) (
  input  logic                  vgaclk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  score_digit_encoder_if.slave  bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  function automatic int max_display(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] raw);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = raw;
    lead = 1'b1;
    // Units digit is never blanked so a zero score still shows "0".
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && raw[4*i +: 4] == 4'd0) res[4*i +: 4] = 4'hF;
      else                                lead = 1'b0;
    end
    return LEAD_BLANK ? res : raw;
  endfunction

  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  localparam int                MAX_VAL    = max_display(NUM_DIGITS);
  localparam logic [VALUE_W-1:0] MAX_CLIP   = VALUE_W'(MAX_VAL);
  localparam logic [BCD_W-1:0]   DIGITS_RST = blank_lead(BCD_W'(0));

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [VALUE_W-1:0] bin, bin_shift;
  logic [BCD_W-1:0]   bcd, bcd_adj, bcd_shift;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   staging;
  logic               pending;
  logic               load, shift_en, last_shift;
  logic               saturate, commit;
  logic [31:0]        value_ext;

  // State register
  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.value_valid) state_nxt = SHIFT;
      SHIFT:   if (last_shift)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.ready = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        load      = bus.value_valid;
      end
      SHIFT:   shift_en = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  assign last_shift = shift_en && (cnt == CNT_W'(VALUE_W - 1));
  assign value_ext  = 32'(bus.value);
  assign saturate   = value_ext > 32'(MAX_VAL);
  assign bcd_adj    = add3_adjust(bcd);
  assign {bcd_shift, bin_shift} = {bcd_adj[BCD_W-2:0], bin, 1'b0};

  // Commit uses the pending flag from before this edge, so a result finishing now waits a frame.
  assign commit = (x == 10'd0) && (y == 10'(COMMIT_LINE)) && pending;

  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      bin         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      staging     <= '0;
      pending     <= 1'b0;
      bus.digits  <= DIGITS_RST;
      bus.updated <= 1'b0;
    end else begin
      if (load) begin
        bin <= saturate ? MAX_CLIP : bus.value;
        bcd <= '0;
        cnt <= '0;
      end else if (shift_en) begin
        bin <= bin_shift;
        bcd <= bcd_shift;
        cnt <= cnt + 1'b1;
      end

      if (last_shift) begin
        staging <= bcd_shift;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      if (commit) bus.digits <= blank_lead(staging);
      bus.updated <= commit;
    end
  end

endmodule

// File: tb/tb_score_digit_encoder.sv
// Directed table-driven bench for score_digit_encoder with a second instance for raw (unblanked) output.
module tb_score_digit_encoder;

  logic       vgaclk = 1'b0;
  logic       rst;
  logic [9:0] x, y;

  always #5 vgaclk = ~vgaclk;

  score_digit_encoder_if #(.VALUE_W(14), .NUM_DIGITS(4)) bus0 ();
  score_digit_encoder_if #(.VALUE_W(14), .NUM_DIGITS(4)) bus1 ();

  score_digit_encoder #(.NUM_DIGITS(4), .VALUE_W(14), .COMMIT_LINE(490), .LEAD_BLANK(1'b1)) dut0 (
    .vgaclk (vgaclk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .bus    (bus0)
  );

  score_digit_encoder #(.NUM_DIGITS(4), .VALUE_W(14), .COMMIT_LINE(490), .LEAD_BLANK(1'b0)) dut1 (
    .vgaclk (vgaclk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .bus    (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [13:0] val;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  // Offer one value to the selected instance; busy returns the number of cycles ready stayed low.
  task automatic offer(input bit sel, input logic [13:0] v, output int busy);
    int w;
    w = 0;
    while ((sel ? bus1.ready : bus0.ready) !== 1'b1 && w < 100) begin
      w++;
      tick();
    end
    if (sel) begin bus1.value = v; bus1.value_valid = 1'b1; end
    else     begin bus0.value = v; bus0.value_valid = 1'b1; end
    tick();
    bus0.value_valid = 1'b0;
    bus1.value_valid = 1'b0;
    busy = 0;
    while ((sel ? bus1.ready : bus0.ready) !== 1'b1 && busy < 100) begin
      busy++;
      tick();
    end
  endtask

  task automatic commit_strobe();
    x = 10'd0;
    y = 10'd490;
    tick();
    x = 10'd5;
    y = 10'd100;
  endtask

  initial begin
    int          busy;
    int          pulses;
    logic [15:0] prev;

    vecs[0] = '{14'd1234,  16'h1234};
    vecs[1] = '{14'd7,     16'hFFF7};
    vecs[2] = '{14'd1005,  16'h1005};
    vecs[3] = '{14'd12000, 16'h9999};
    vecs[4] = '{14'd0,     16'hFFF0};
    vecs[5] = '{14'd10,    16'hFF10};
    vecs[6] = '{14'd100,   16'hF100};
    vecs[7] = '{14'd9999,  16'h9999};
    vecs[8] = '{14'd10000, 16'h9999};
    vecs[9] = '{14'd16383, 16'h9999};

    rst = 1'b1;
    x = 10'd5;
    y = 10'd100;
    bus0.value = '0; bus0.value_valid = 1'b0;
    bus1.value = '0; bus1.value_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_digits", 32'(bus0.digits), 32'h0000FFF0);
    chk("rst_ready", 32'(bus0.ready), 32'd1);
    chk("rst_updated", 32'(bus0.updated), 32'd0);
    chk("rst_digits_raw", 32'(bus1.digits), 32'h00000000);

    // Sweep across the commit line with nothing pending: no pulse expected.
    pulses = 0;
    for (int yy = 485; yy <= 495; yy++) begin
      for (int xx = 0; xx < 4; xx++) begin
        x = 10'(xx);
        y = 10'(yy);
        tick();
        if (bus0.updated === 1'b1) pulses++;
      end
    end
    x = 10'd5;
    y = 10'd100;
    chk("idle_frame_pulses", 32'(pulses), 32'd0);
    chk("idle_frame_digits", 32'(bus0.digits), 32'h0000FFF0);

    prev = 16'hFFF0;
    for (int i = 0; i < 10; i++) begin
      offer(1'b0, vecs[i].val, busy);
      chk($sformatf("busy_cycles[%0d]", i), 32'(busy), 32'd14);
      chk($sformatf("hold_before_commit[%0d]", i), 32'(bus0.digits), 32'(prev));
      commit_strobe();
      chk($sformatf("digits[%0d]", i), 32'(bus0.digits), 32'(vecs[i].exp));
      chk($sformatf("updated_hi[%0d]", i), 32'(bus0.updated), 32'd1);
      tick();
      chk($sformatf("updated_lo[%0d]", i), 32'(bus0.updated), 32'd0);
      prev = vecs[i].exp;
    end

    offer(1'b1, 14'd7, busy);
    commit_strobe();
    chk("raw_digits_7", 32'(bus1.digits), 32'h00000007);
    chk("raw_updated", 32'(bus1.updated), 32'd1);
    chk("blank_no_pending_hold", 32'(bus0.digits), 32'h00009999);

    // Near misses of the commit position must not commit.
    offer(1'b0, 14'd500, busy);
    x = 10'd1; y = 10'd490; tick();
    x = 10'd0; y = 10'd489; tick();
    x = 10'd0; y = 10'd491; tick();
    x = 10'd5; y = 10'd100;
    chk("near_miss_digits", 32'(bus0.digits), 32'h00009999);
    chk("near_miss_updated", 32'(bus0.updated), 32'd0);
    commit_strobe();
    chk("after_near_miss", 32'(bus0.digits), 32'h0000F500);

    // Two conversions before one commit: only the latest is shown.
    offer(1'b0, 14'd42, busy);
    offer(1'b0, 14'd58, busy);
    commit_strobe();
    chk("latest_wins", 32'(bus0.digits), 32'h0000FF58);
    chk("latest_updated", 32'(bus0.updated), 32'd1);
    tick();
    commit_strobe();
    chk("second_strobe_no_pulse", 32'(bus0.updated), 32'd0);
    chk("second_strobe_digits", 32'(bus0.digits), 32'h0000FF58);

    // Conversion finishing on the commit edge: old pending shown now, new one next frame.
    offer(1'b0, 14'd11, busy);
    bus0.value = 14'd22;
    bus0.value_valid = 1'b1;
    tick();
    bus0.value_valid = 1'b0;
    repeat (13) tick();
    chk("coincide_still_busy", 32'(bus0.ready), 32'd0);
    x = 10'd0; y = 10'd490;
    tick();
    x = 10'd5; y = 10'd100;
    chk("coincide_digits_old", 32'(bus0.digits), 32'h0000FF11);
    chk("coincide_updated", 32'(bus0.updated), 32'd1);
    chk("coincide_ready", 32'(bus0.ready), 32'd1);
    tick();
    commit_strobe();
    chk("coincide_next_frame", 32'(bus0.digits), 32'h0000FF22);

    // Reset mid-conversion discards everything, asynchronously.
    tick();
    bus0.value = 14'd33;
    bus0.value_valid = 1'b1;
    tick();
    bus0.value_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("async_rst_digits", 32'(bus0.digits), 32'h0000FFF0);
    chk("async_rst_ready", 32'(bus0.ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    commit_strobe();
    chk("post_rst_no_commit", 32'(bus0.updated), 32'd0);
    chk("post_rst_digits", 32'(bus0.digits), 32'h0000FFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
